// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: select-width helpers and flat-bus slicing.
// Pure declarations, no logic or state.
`ifndef XBAR_PKG_SV
`define XBAR_PKG_SV
`define XBAR_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package xbar_pkg;

   localparam int XBAR_MAX_PORTS = 16;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int b = 0; b < 31; b++) begin
         if ((1 << b) < n) r = b + 1;
      end
      return r;
   endfunction

   // A one-port-wide select would collapse to zero bits; keep at least one.
   function automatic int sel_w(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage
`endif

// File: rtl/xbar_switch_rr_arbiter.sv
// Combinational round-robin arbiter: priority starts at ptr_i and wraps upward.
// Zero latency, no state; the caller decides whether a grant is consumed.
module rr_arbiter
   import xbar_pkg::*;
#(
   parameter  int P_N = 4,
   localparam int PW  = sel_w(P_N)
) (
   input  logic [P_N-1:0] req_i,
   input  logic [PW-1:0]  ptr_i,
   output logic [P_N-1:0] grant_o,
   output logic [PW-1:0]  idx_o,
   output logic           any_o
);

   int            cand;
   logic [PW-1:0] cand_sel;
   logic          found;

   always_comb begin
      grant_o  = '0;
      idx_o    = '0;
      found    = 1'b0;
      cand     = 0;
      cand_sel = '0;
      for (int k = 0; k < P_N; k++) begin
         cand = int'(ptr_i) + k;
         if (cand >= P_N) cand = cand - P_N;
         cand_sel = PW'(cand);
         if (!found && req_i[cand_sel]) begin
            found             = 1'b1;
            grant_o[cand_sel] = 1'b1;
            idx_o             = cand_sel;
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/xbar_switch.sv
// Registered P_PORTS x P_PORTS crossbar with per-output round-robin and 1-entry output register.
// Latency 1 clk; in_ready follows grant & (!out_valid | out_ready), so a stalled output holds its requesters.
module xbar_switch
   import xbar_pkg::*;
#(
   parameter  int P_WIDTH = 32,
   parameter  int P_PORTS = 4,
   localparam int SEL_W   = sel_w(P_PORTS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [P_PORTS*P_WIDTH-1:0] in_data,
   input  logic [P_PORTS*SEL_W-1:0]   in_dest,
   input  logic [P_PORTS-1:0]         in_valid,
   output logic [P_PORTS-1:0]         in_ready,
   output logic [P_PORTS*P_WIDTH-1:0] out_data,
   output logic [P_PORTS*SEL_W-1:0]   out_src,
   output logic [P_PORTS-1:0]         out_valid,
   input  logic [P_PORTS-1:0]         out_ready,
   output logic                       drop_err
);

   logic [P_PORTS-1:0] req      [P_PORTS];
   logic [P_PORTS-1:0] gnt      [P_PORTS];
   logic [SEL_W-1:0]   gnt_idx  [P_PORTS];
   logic [P_PORTS-1:0] gnt_any;
   logic [P_PORTS-1:0] can_load;
   logic [P_PORTS-1:0] load;
   logic [P_PORTS-1:0] bad_dest;
   logic               drop_d;
   logic               drop_q;

   logic               out_valid_q [P_PORTS];
   logic [P_WIDTH-1:0] out_data_q  [P_PORTS];
   logic [SEL_W-1:0]   out_src_q   [P_PORTS];
   logic [SEL_W-1:0]   ptr_q       [P_PORTS];

   // req[j][i]: input i wants output j this cycle
   always_comb begin
      for (int j = 0; j < P_PORTS; j++) begin
         req[j] = '0;
         for (int i = 0; i < P_PORTS; i++) begin
            req[j][i] = in_valid[i] && (`XBAR_SLICE(in_dest, i, SEL_W) == SEL_W'(j));
         end
      end
   end

   for (genvar i = 0; i < P_PORTS; i++) begin : g_dest
      if (P_PORTS == (1 << SEL_W)) begin : g_full
         assign bad_dest[i] = 1'b0;
      end else begin : g_partial
         assign bad_dest[i] = (`XBAR_SLICE(in_dest, i, SEL_W) >= SEL_W'(P_PORTS));
      end
   end

   // Out-of-range words are swallowed so the producer never deadlocks on them.
   always_comb begin
      in_ready = in_valid & bad_dest;
      for (int j = 0; j < P_PORTS; j++) begin
         for (int i = 0; i < P_PORTS; i++) begin
            in_ready[i] = in_ready[i] | (gnt[j][i] & can_load[j]);
         end
      end
   end

   assign drop_d = |(in_valid & bad_dest);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q <= 1'b0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_err = drop_q;

   for (genvar j = 0; j < P_PORTS; j++) begin : g_out
      rr_arbiter #(.P_N(P_PORTS)) u_arb (
         .req_i   (req[j]),
         .ptr_i   (ptr_q[j]),
         .grant_o (gnt[j]),
         .idx_o   (gnt_idx[j]),
         .any_o   (gnt_any[j])
      );

      assign can_load[j] = ~out_valid_q[j] | out_ready[j];
      assign load[j]     = can_load[j] & gnt_any[j];

      // Pointer only advances on a real load, so a stalled output keeps its fairness order.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            out_valid_q[j] <= 1'b0;
            out_data_q[j]  <= '0;
            out_src_q[j]   <= '0;
            ptr_q[j]       <= '0;
         end else if (load[j]) begin
            out_valid_q[j] <= 1'b1;
            out_data_q[j]  <= in_data[gnt_idx[j]*P_WIDTH +: P_WIDTH];
            out_src_q[j]   <= gnt_idx[j];
            ptr_q[j]       <= (gnt_idx[j] == SEL_W'(P_PORTS - 1)) ? '0 : gnt_idx[j] + 1'b1;
         end else if (out_ready[j]) begin
            out_valid_q[j] <= 1'b0;
         end
      end

      assign out_valid[j]                    = out_valid_q[j];
      assign `XBAR_SLICE(out_data, j, P_WIDTH) = out_data_q[j];
      assign `XBAR_SLICE(out_src, j, SEL_W)    = out_src_q[j];
   end

endmodule

// File: tb/tb_xbar_switch.sv
// Bench for xbar_switch: directed scenarios plus random traffic against a queue-free reference model.
module tb_xbar_switch;

   localparam int W  = 32;
   localparam int NP = 4;
   localparam int SW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NP*W-1:0]  in_data;
   logic [NP*SW-1:0] in_dest;
   logic [NP-1:0]    in_valid, in_ready, out_valid, out_ready;
   logic [NP*W-1:0]  out_data;
   logic [NP*SW-1:0] out_src;
   logic             drop_err;

   logic [3*W-1:0]   in_data3, out_data3;
   logic [5:0]       in_dest3, out_src3;
   logic [2:0]       in_valid3, in_ready3, out_valid3, out_ready3;
   logic             drop_err3;

   logic [W-1:0]     idat [NP];
   logic [SW-1:0]    idst [NP];

   always_comb begin
      in_data = '0;
      in_dest = '0;
      for (int i = 0; i < NP; i++) begin
         in_data[i*W +: W]   = idat[i];
         in_dest[i*SW +: SW] = idst[i];
      end
   end

   xbar_switch #(.P_WIDTH(W), .P_PORTS(NP)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_dest(in_dest), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready),
      .drop_err(drop_err)
   );

   xbar_switch #(.P_WIDTH(W), .P_PORTS(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data3), .in_dest(in_dest3), .in_valid(in_valid3), .in_ready(in_ready3),
      .out_data(out_data3), .out_src(out_src3), .out_valid(out_valid3), .out_ready(out_ready3),
      .drop_err(drop_err3)
   );

   int n_asrt = 0;
   int n_fail = 0;

   // Reference state: what each output register should hold, and where its fairness pointer sits.
   logic         m_valid [NP];
   logic [W-1:0] m_data  [NP];
   int           m_src   [NP];
   int           m_ptr   [NP];
   logic         n_valid [NP];
   logic [W-1:0] n_data  [NP];
   int           n_src   [NP];
   int           n_ptr   [NP];
   logic [NP-1:0] exp_rdy;
   logic [NP-1:0] obs_rdy;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < NP; j++) begin
         m_valid[j] = 1'b0;
         m_data[j]  = '0;
         m_src[j]   = 0;
         m_ptr[j]   = 0;
      end
   endtask

   task automatic model_eval();
      exp_rdy = '0;
      for (int j = 0; j < NP; j++) begin
         int win;
         win = -1;
         n_valid[j] = m_valid[j];
         n_data[j]  = m_data[j];
         n_src[j]   = m_src[j];
         n_ptr[j]   = m_ptr[j];
         if (!m_valid[j] || out_ready[j]) begin
            for (int k = 0; k < NP; k++) begin
               int c;
               c = (m_ptr[j] + k) % NP;
               if (win < 0 && in_valid[c] && int'(idst[c]) == j) win = c;
            end
            if (win >= 0) begin
               exp_rdy[win] = 1'b1;
               n_valid[j]   = 1'b1;
               n_data[j]    = idat[win];
               n_src[j]     = win;
               n_ptr[j]     = (win + 1) % NP;
            end else begin
               n_valid[j] = 1'b0;
            end
         end
      end
   endtask

   // One clock: check in_ready mid-cycle, then every output register just after the edge.
   task automatic step();
      model_eval();
      #1;
      obs_rdy = in_ready;
      chk("in_ready", in_ready, exp_rdy);
      @(posedge clk);
      for (int j = 0; j < NP; j++) begin
         m_valid[j] = n_valid[j];
         m_data[j]  = n_data[j];
         m_src[j]   = n_src[j];
         m_ptr[j]   = n_ptr[j];
      end
      #1;
      for (int j = 0; j < NP; j++) begin
         chk("out_valid", out_valid[j], m_valid[j]);
         chk("out_data", out_data[j*W +: W], m_data[j]);
         chk("out_src", out_src[j*SW +: SW], 64'(m_src[j]));
      end
      chk("drop_err", drop_err, 1'b0);
   endtask

   initial begin
      in_valid   = '0;
      out_ready  = '1;
      for (int i = 0; i < NP; i++) begin
         idat[i] = '0;
         idst[i] = '0;
      end
      in_data3   = '0;
      in_dest3   = '0;
      in_valid3  = '0;
      out_ready3 = '1;
      model_reset();

      // Reset state
      #12;
      chk("rst_out_valid", out_valid, 4'h0);
      chk("rst_out_data", out_data, '0);
      chk("rst_out_src", out_src, '0);
      chk("rst_drop", drop_err, 1'b0);
      chk("rst_out_valid3", out_valid3, 3'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Contention: everyone targets output 2, grants rotate 0,1,2,3 twice
      in_valid = 4'hF;
      for (int i = 0; i < NP; i++) begin
         idst[i] = 2'd2;
         idat[i] = 32'hC0 + i;
      end
      for (int k = 0; k < 8; k++) begin
         step();
         chk("cont_src", out_src[2*SW +: SW], 64'(k % 4));
         chk("cont_data", out_data[2*W +: W], 64'(32'hC0 + (k % 4)));
      end
      in_valid = '0;
      step();

      // Permutation: input i -> output 3-i, all in one cycle
      in_valid = 4'hF;
      for (int i = 0; i < NP; i++) begin
         idst[i] = 2'(3 - i);
         idat[i] = 32'hA0 + i;
      end
      step();
      chk("perm_rdy", obs_rdy, 4'hF);
      for (int j = 0; j < NP; j++) chk("perm_data", out_data[j*W +: W], 64'(32'hA0 + (3 - j)));
      in_valid = '0;
      step();

      // Backpressure on output 1
      in_valid = 4'b0001;
      idst[0] = 2'd1;
      idat[0] = 32'hB0;
      step();
      out_ready[1] = 1'b0;
      idat[0] = 32'hB1;
      in_valid = 4'b0101;
      idst[2] = 2'd1;
      idat[2] = 32'hB2;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("bp_hold_data", out_data[W +: W], 32'hB0);
         chk("bp_rdy", {obs_rdy[2], obs_rdy[0]}, 2'b00);
      end
      out_ready[1] = 1'b1;
      step();
      chk("bp_release_valid", out_valid[1], 1'b1);
      chk("bp_release_data", out_data[W +: W], 32'hB2);
      in_valid = 4'b0001;
      step();
      chk("bp_second_data", out_data[W +: W], 32'hB1);
      in_valid = '0;
      step();

      // Pointer hold on output 2: stalled cycles must not move the pointer
      out_ready[2] = 1'b0;
      in_valid = 4'b0010;
      idst[1] = 2'd2;
      idat[1] = 32'hD1;
      step();
      idat[1] = 32'hD2;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("ph_rdy", obs_rdy[1], 1'b0);
         chk("ph_data", out_data[2*W +: W], 32'hD1);
      end
      out_ready[2] = 1'b1;
      step();
      chk("ph_win_rdy", obs_rdy[1], 1'b1);
      chk("ph_win_src", out_src[2*SW +: SW], 2'd1);
      in_valid = 4'b0110;
      idat[1] = 32'hE1;
      idst[2] = 2'd2;
      idat[2] = 32'hE2;
      step();
      chk("ph_ptr_src", out_src[2*SW +: SW], 2'd2);
      in_valid = 4'b0010;
      step();
      chk("ph_next_src", out_src[2*SW +: SW], 2'd1);
      in_valid = '0;
      step();

      // Random traffic; producers hold a word until it is accepted
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NP; i++) begin
            if (!(in_valid[i] && !exp_rdy[i])) begin
               in_valid[i] = ($urandom_range(0, 3) != 0);
               idat[i]     = $urandom;
               idst[i]     = 2'($urandom_range(0, 3));
            end
         end
         out_ready = 4'($urandom);
         step();
      end

      // Reset in the middle of traffic
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 4'h0);
      chk("midrst_drop", drop_err, 1'b0);
      model_reset();
      in_valid  = '0;
      out_ready = '1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      in_valid = 4'b1000;
      idst[3] = 2'd0;
      idat[3] = 32'h77;
      step();
      chk("midrst_first_valid", out_valid, 4'b0001);
      chk("midrst_first_data", out_data[0 +: W], 32'h77);
      in_valid = '0;
      step();

      // Three-port instance: out-of-range destination is dropped and flagged
      in_valid3 = 3'b001;
      in_dest3  = 6'b00_00_11;
      in_data3  = {32'h0, 32'h0, 32'h99};
      #1;
      chk("drop_rdy", in_ready3[0], 1'b1);
      @(posedge clk);
      #1;
      chk("drop_no_valid", out_valid3, 3'b000);
      chk("drop_err_pulse", drop_err3, 1'b1);
      in_valid3 = 3'b010;
      in_dest3  = 6'b00_10_00;
      in_data3  = {32'h0, 32'h5A, 32'h0};
      #1;
      chk("p3_rdy", in_ready3, 3'b010);
      @(posedge clk);
      #1;
      chk("drop_err_clear", drop_err3, 1'b0);
      chk("p3_valid", out_valid3, 3'b100);
      chk("p3_data", out_data3[2*W +: W], 32'h5A);
      chk("p3_src", out_src3[5:4], 2'd1);
      in_valid3 = '0;
      @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
